// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI-Lite response codes, FSM state types and access-counter offsets
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [11:0] CNT_WR_OFF = 12'hFF8;
    localparam logic [11:0] CNT_RD_OFF = 12'hFFC;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI-Lite bus bundle with master and slave views
interface axi_lite_if;
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;
    modport master (
        output aw_addr, aw_valid, w_data, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
    modport slave (
        input  aw_addr, aw_valid, w_data, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axi_lite_sat_cnt.sv
// axi_lite_sat_cnt: 32-bit saturating event counter, clear wins over increment
module axi_lite_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] cnt
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 32'd1;
endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI-Lite responder over NUM_CTRL r/w control and NUM_STAT read-only status registers
// AXIL_ACCESS_CNT_EN adds read-only write/read handshake counters at 0xFF8/0xFFC
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int          NUM_CTRL   = 8,
    parameter int          NUM_STAT   = 8,
    parameter logic [31:0] STAT_BASE  = 32'h100,
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] CTRL_RST   = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_lite_if.slave                 s_axil,
    output logic [NUM_CTRL-1:0][31:0] ctrl_regs,
    output logic [NUM_CTRL-1:0]       ctrl_wr_pulse,
    input  logic [NUM_STAT-1:0][31:0] stat_regs
);
    w_state_t              w_st;
    r_state_t              r_st;
    logic                  aw_held, w_held, aw_hs, w_hs, ar_hs, commit, w_cnt, w_ok, r_hit;
    logic [31:0]           aw_q, w_q, w_val, r_val;
    logic [ADDR_WIDTH-1:0] w_off, r_off;
    logic [NUM_CTRL-1:0]   w_sel;
    assign aw_hs  = s_axil.aw_valid & s_axil.aw_ready;
    assign w_hs   = s_axil.w_valid & s_axil.w_ready;
    assign ar_hs  = s_axil.ar_valid & s_axil.ar_ready;
    assign commit = (w_st == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign w_val  = w_held ? w_q : s_axil.w_data;
    assign w_off  = ADDR_WIDTH'((aw_held ? aw_q : s_axil.aw_addr) & ~32'h3);
    assign r_off  = ADDR_WIDTH'(s_axil.ar_addr & ~32'h3);
    assign w_ok   = (|w_sel) || w_cnt;
`ifdef AXIL_ACCESS_CNT_EN
    logic [31:0] wr_cnt, rd_cnt;
    assign w_cnt = w_off == ADDR_WIDTH'(CNT_WR_OFF) || w_off == ADDR_WIDTH'(CNT_RD_OFF);
    axi_lite_sat_cnt u_wr_cnt (.clk(clk), .rst(rst), .inc(s_axil.b_valid & s_axil.b_ready),
                               .clr(commit & w_cnt), .cnt(wr_cnt));
    axi_lite_sat_cnt u_rd_cnt (.clk(clk), .rst(rst), .inc(s_axil.r_valid & s_axil.r_ready),
                               .clr(commit & w_cnt), .cnt(rd_cnt));
`else
    assign w_cnt = 1'b0;
`endif
    always_comb begin
        w_sel = '0;
        r_val = '0;
        r_hit = 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            w_sel[i] = w_off == ADDR_WIDTH'(4 * i);
            if (r_off == ADDR_WIDTH'(4 * i)) begin
                r_val = ctrl_regs[i];
                r_hit = 1'b1;
            end
        end
        for (int j = 0; j < NUM_STAT; j++)
            if (r_off == ADDR_WIDTH'(STAT_BASE + 32'(4 * j))) begin
                r_val = stat_regs[j];
                r_hit = 1'b1;
            end
`ifdef AXIL_ACCESS_CNT_EN
        if (r_off == ADDR_WIDTH'(CNT_WR_OFF)) begin
            r_val = wr_cnt;
            r_hit = 1'b1;
        end
        if (r_off == ADDR_WIDTH'(CNT_RD_OFF)) begin
            r_val = rd_cnt;
            r_hit = 1'b1;
        end
`endif
    end
    // AW and W latch independently; the write lands on the first edge holding both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_st            <= W_IDLE;
            s_axil.aw_ready <= 1'b0;
            s_axil.w_ready  <= 1'b0;
            s_axil.b_valid  <= 1'b0;
            s_axil.b_resp   <= RESP_OKAY;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            aw_q            <= '0;
            w_q             <= '0;
            ctrl_regs       <= {NUM_CTRL{CTRL_RST}};
            ctrl_wr_pulse   <= '0;
        end else begin
            ctrl_wr_pulse <= '0;
            if (w_st == W_IDLE) begin
                if (commit) begin
                    w_st            <= W_RESP;
                    s_axil.aw_ready <= 1'b0;
                    s_axil.w_ready  <= 1'b0;
                    s_axil.b_valid  <= 1'b1;
                    s_axil.b_resp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
                    ctrl_wr_pulse   <= w_sel;
                    for (int i = 0; i < NUM_CTRL; i++)
                        if (w_sel[i]) ctrl_regs[i] <= w_val;
                end else begin
                    aw_held         <= aw_held | aw_hs;
                    w_held          <= w_held | w_hs;
                    s_axil.aw_ready <= !(aw_held | aw_hs);
                    s_axil.w_ready  <= !(w_held | w_hs);
                    if (aw_hs) aw_q <= s_axil.aw_addr;
                    if (w_hs) w_q <= s_axil.w_data;
                end
            end else if (s_axil.b_ready) begin
                w_st            <= W_IDLE;
                s_axil.b_valid  <= 1'b0;
                s_axil.aw_ready <= 1'b1;
                s_axil.w_ready  <= 1'b1;
                aw_held         <= 1'b0;
                w_held          <= 1'b0;
            end
        end
    end
    // read data is captured at AR acceptance, so a same-edge write is not yet visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st            <= R_IDLE;
            s_axil.ar_ready <= 1'b0;
            s_axil.r_valid  <= 1'b0;
            s_axil.r_data   <= '0;
            s_axil.r_resp   <= RESP_OKAY;
        end else if (r_st == R_IDLE) begin
            s_axil.ar_ready <= !ar_hs;
            if (ar_hs) begin
                r_st           <= R_DATA;
                s_axil.r_valid <= 1'b1;
                s_axil.r_data  <= r_val;
                s_axil.r_resp  <= r_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end else if (s_axil.r_ready) begin
            r_st            <= R_IDLE;
            s_axil.r_valid  <= 1'b0;
            s_axil.ar_ready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: vector table, corner sequences and random traffic against a register-map model
module tb_axi_lite_reg_slave;
    import axi_lite_pkg::*;
`ifdef AXIL_ACCESS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0][31:0] ctrl_regs;
    logic [7:0]       ctrl_wr_pulse;
    logic [7:0][31:0] stat_regs;
    logic [31:0] stat_m [8];
    logic [31:0] ctrl_m [8];
    logic [31:0] wr_cnt_m, rd_cnt_m;
    int vectors = 0;
    int miscompares = 0;
    vec_t tbl [13];

    axi_lite_if s ();
    axi_lite_reg_slave dut (
        .clk(clk), .rst(rst), .s_axil(s),
        .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .stat_regs(stat_regs)
    );

    always #5 clk = ~clk;
    always_comb for (int j = 0; j < 8; j++) stat_regs[j] = stat_m[j];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out", name);
    endtask

    // register map: 8 ctrl words at 0x000, 8 stat words at 0x100, optional counters; 12-bit window
    function automatic void model_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic [11:0] off;
        off = a[11:0] & 12'hFFC;
        d = 32'h0;
        r = RESP_SLVERR;
        if (off < 12'h020) begin
            d = ctrl_m[off[4:2]];
            r = RESP_OKAY;
        end else if (off >= 12'h100 && off < 12'h120) begin
            d = stat_m[off[4:2]];
            r = RESP_OKAY;
        end else if (CNT_EN && off == 12'hFF8) begin
            d = wr_cnt_m;
            r = RESP_OKAY;
        end else if (CNT_EN && off == 12'hFFC) begin
            d = rd_cnt_m;
            r = RESP_OKAY;
        end
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d,
                                     output logic [1:0] r, output logic [7:0] p);
        logic [11:0] off;
        off = a[11:0] & 12'hFFC;
        p = 8'h0;
        r = RESP_SLVERR;
        if (off < 12'h020) begin
            ctrl_m[off[4:2]] = d;
            p = 8'h1 << off[4:2];
            r = RESP_OKAY;
        end else if (CNT_EN && (off == 12'hFF8 || off == 12'hFFC)) begin
            wr_cnt_m = 32'h0;
            rd_cnt_m = 32'h0;
            r = RESP_OKAY;
        end
    endfunction

    task automatic check_ctrl();
        for (int i = 0; i < 8; i++) check("ctrl_regs", ctrl_regs[i], ctrl_m[i]);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int aw_dly, input int w_dly,
                             input int b_dly, input logic [1:0] exp_r, input logic [7:0] exp_p);
        int cyc;
        bit aw_done, w_done, hs_aw, hs_w;
        cyc = 0;
        aw_done = 1'b0;
        w_done = 1'b0;
        while (!(aw_done && w_done)) begin
            s.aw_addr = a;
            s.w_data = d;
            s.aw_valid = !aw_done && cyc >= aw_dly;
            s.w_valid = !w_done && cyc >= w_dly;
            hs_aw = s.aw_valid && s.aw_ready;
            hs_w = s.w_valid && s.w_ready;
            @(negedge clk);
            aw_done = aw_done || hs_aw;
            w_done = w_done || hs_w;
            if (hs_w && !aw_done) check("w_ready_drop", 32'(s.w_ready), 32'h0);
            if (hs_aw && !w_done) check("aw_ready_drop", 32'(s.aw_ready), 32'h0);
            cyc++;
            if (cyc > 40) begin
                fail("aw_w_handshake");
                break;
            end
        end
        s.aw_valid = 1'b0;
        s.w_valid = 1'b0;
        check("b_latency", 32'(s.b_valid), 32'h1);
        check("wr_pulse", 32'(ctrl_wr_pulse), 32'(exp_p));
        for (int bc = 0; bc < 50; bc++) begin
            s.b_ready = bc >= b_dly;
            if (!s.b_valid) begin
                fail("b_valid_hold");
                break;
            end
            check("b_resp", 32'(s.b_resp), 32'(exp_r));
            @(negedge clk);
            if (s.b_ready) break;
        end
        s.b_ready = 1'b0;
        check("w_idle", 32'({s.aw_ready, s.w_ready}), 32'h3);
        check("pulse_width", 32'(ctrl_wr_pulse), 32'h0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_dly,
                            input logic [31:0] exp_d, input logic [1:0] exp_r);
        int cyc;
        bit hs;
        cyc = 0;
        hs = 1'b0;
        while (!hs) begin
            s.ar_addr = a;
            s.ar_valid = 1'b1;
            hs = s.ar_ready;
            @(negedge clk);
            cyc++;
            if (!hs && cyc > 40) begin
                fail("ar_handshake");
                break;
            end
        end
        s.ar_valid = 1'b0;
        check("r_latency", 32'(s.r_valid), 32'h1);
        for (int k = 0; k < r_dly; k++) begin
            check("r_data_hold", s.r_data, exp_d);
            @(negedge clk);
            check("r_valid_hold", 32'(s.r_valid), 32'h1);
        end
        check("r_data", s.r_data, exp_d);
        check("r_resp", 32'(s.r_resp), 32'(exp_r));
        s.r_ready = 1'b1;
        @(negedge clk);
        s.r_ready = 1'b0;
        check("ar_idle", 32'(s.ar_ready), 32'h1);
    endtask

    initial begin
        logic [31:0] ed;
        logic [1:0] er, er2;
        logic [7:0] ep;
        s.aw_valid = 1'b0; s.w_valid = 1'b0; s.b_ready = 1'b0; s.ar_valid = 1'b0; s.r_ready = 1'b0;
        s.aw_addr = '0; s.w_data = '0; s.ar_addr = '0;
        for (int j = 0; j < 8; j++) begin
            stat_m[j] = 32'hA5A5_0000 | 32'(j);
            ctrl_m[j] = 32'h0;
        end
        wr_cnt_m = 32'h0;
        rd_cnt_m = 32'h0;
        tbl[0]  = '{1'b1, 32'h004, 32'hDEAD_BEEF, RESP_OKAY, 32'h0};
        tbl[1]  = '{1'b0, 32'h004, 32'h0, RESP_OKAY, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 32'h10C, 32'h0, RESP_OKAY, 32'hA5A5_0003};
        tbl[3]  = '{1'b0, 32'h300, 32'h0, RESP_SLVERR, 32'h0};
        tbl[4]  = '{1'b1, 32'h100, 32'h1111_1111, RESP_SLVERR, 32'h0};
        tbl[5]  = '{1'b0, 32'h100, 32'h0, RESP_OKAY, 32'hA5A5_0000};
        tbl[6]  = '{1'b1, 32'h101F, 32'h0000_0077, RESP_OKAY, 32'h0};
        tbl[7]  = '{1'b0, 32'h01C, 32'h0, RESP_OKAY, 32'h0000_0077};
        tbl[8]  = '{1'b0, 32'hFF8, 32'h0, CNT_EN ? RESP_OKAY : RESP_SLVERR, CNT_EN ? 32'd3 : 32'd0};
        tbl[9]  = '{1'b0, 32'hFFC, 32'h0, CNT_EN ? RESP_OKAY : RESP_SLVERR, CNT_EN ? 32'd6 : 32'd0};
        tbl[10] = '{1'b1, 32'hFF8, 32'h0, CNT_EN ? RESP_OKAY : RESP_SLVERR, 32'h0};
        tbl[11] = '{1'b0, 32'hFFC, 32'h0, CNT_EN ? RESP_OKAY : RESP_SLVERR, 32'd0};
        tbl[12] = '{1'b0, 32'hFF8, 32'h0, CNT_EN ? RESP_OKAY : RESP_SLVERR, CNT_EN ? 32'd1 : 32'd0};

        repeat (2) @(negedge clk);
        check("rst_aw_ready", 32'(s.aw_ready), 32'h0);
        check("rst_w_ready", 32'(s.w_ready), 32'h0);
        check("rst_ar_ready", 32'(s.ar_ready), 32'h0);
        check("rst_b_valid", 32'(s.b_valid), 32'h0);
        check("rst_r_valid", 32'(s.r_valid), 32'h0);
        check("rst_r_data", s.r_data, 32'h0);
        check("rst_resps", 32'({s.r_resp, s.b_resp}), 32'h0);
        check("rst_pulse", 32'(ctrl_wr_pulse), 32'h0);
        check_ctrl();
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'({s.aw_ready, s.w_ready, s.ar_ready}), 32'h7);

        for (int k = 0; k < 13; k++) begin
            if (tbl[k].wr) begin
                model_wr(tbl[k].addr, tbl[k].data, er, ep);
                axi_write(tbl[k].addr, tbl[k].data, 0, 0, 0, tbl[k].resp, ep);
                check_ctrl();
                wr_cnt_m++;
            end else begin
                axi_read(tbl[k].addr, 0, tbl[k].rdata, tbl[k].resp);
                rd_cnt_m++;
            end
        end

        // W three cycles ahead of AW, response held off for five cycles
        model_wr(32'h008, 32'h1234_5678, er, ep);
        axi_write(32'h008, 32'h1234_5678, 3, 0, 5, RESP_OKAY, 8'h04);
        check("ctrl2", ctrl_regs[2], 32'h1234_5678);
        wr_cnt_m++;

        // read and write of ctrl0 accepted on the same edge: read sees the old value
        model_rd(32'h000, ed, er);
        model_wr(32'h000, 32'h1, er2, ep);
        fork
            axi_write(32'h000, 32'h1, 0, 0, 0, er2, ep);
            axi_read(32'h000, 0, ed, er);
        join
        wr_cnt_m++;
        rd_cnt_m++;
        axi_read(32'h000, 0, 32'h1, RESP_OKAY);
        rd_cnt_m++;

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a, d;
            int kind;
            kind = int'($urandom_range(0, 4));
            a = kind <= 1 ? 32'($urandom_range(0, 7) * 4) :
                kind == 2 ? 32'h100 + 32'($urandom_range(0, 7) * 4) :
                kind == 3 ? 32'($urandom_range(32'h48, 32'h3FD) * 4) :
                            32'hFF8 + 32'($urandom_range(0, 1) * 4);
            a = ($urandom & 32'hFFFF_F000) | a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) stat_m[3'($urandom_range(0, 7))] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                model_wr(a, d, er, ep);
                axi_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), er, ep);
                check_ctrl();
                wr_cnt_m++;
            end else begin
                model_rd(a, ed, er);
                axi_read(a, int'($urandom_range(0, 3)), ed, er);
                rd_cnt_m++;
            end
        end

        // reset while a write response is pending
        s.aw_addr = 32'h00C;
        s.w_data = 32'h55;
        s.aw_valid = 1'b1;
        s.w_valid = 1'b1;
        s.b_ready = 1'b0;
        @(negedge clk);
        s.aw_valid = 1'b0;
        s.w_valid = 1'b0;
        check("pre_rst_b_valid", 32'(s.b_valid), 32'h1);
        check("pre_rst_ctrl3", ctrl_regs[3], 32'h55);
        #2 rst = 1'b1;
        #1;
        check("async_b_valid", 32'(s.b_valid), 32'h0);
        check("async_ctrl3", ctrl_regs[3], 32'h0);
        check("async_aw_ready", 32'(s.aw_ready), 32'h0);
        for (int j = 0; j < 8; j++) ctrl_m[j] = 32'h0;
        wr_cnt_m = 32'h0;
        rd_cnt_m = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_ctrl();
        axi_read(32'h00C, 0, 32'h0, RESP_OKAY);
        axi_read(32'h004, 1, 32'h0, RESP_OKAY);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
